// File: rtl/snake_pkg.sv
// Shared types for the snake engine: directions, game states, turn requests,
// body coordinates and LFSR constants used when SNAKE_FOOD_EN is defined.
package snake_pkg;

    // Coordinates are sized for grids up to 256 per side; LFSR bytes map onto them directly.
    localparam int COORD_W = 8;

    typedef enum logic [1:0] {
        DIR_E = 2'd0,
        DIR_S = 2'd1,
        DIR_W = 2'd2,
        DIR_N = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TURN_NONE = 2'd0,
        TURN_CW   = 2'd1,
        TURN_CCW  = 2'd2
    } turn_e;

    typedef struct packed {
        logic [COORD_W-1:0] r;
        logic [COORD_W-1:0] c;
    } coord_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;  // taps 16,14,13,11

    function automatic dir_e apply_turn(dir_e d, turn_e t);
        case (t)
            TURN_CW:  return dir_e'(d + 2'd1);
            TURN_CCW: return dir_e'(d - 2'd1);
            default:  return d;
        endcase
    endfunction

endpackage

// File: rtl/snake_scan.sv
// Row-multiplexed LED driver: one active-low row per cycle, columns lit from
// the body buffer (and optional food cell), both outputs registered.
module snake_scan
    import snake_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int MAX_LEN = 16
) (
    input  logic                         clkSlw,
    input  logic                         reset,
    input  coord_t                       body [MAX_LEN],
    input  logic [$clog2(MAX_LEN+1)-1:0] length,
    input  coord_t                       food,
    input  logic                         food_valid,
    output logic [ROWS-1:0]              row_n,
    output logic [COLS-1:0]              col
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int SW = $clog2(ROWS);

    logic [SW-1:0]   scan_reg, scan_next;
    logic [ROWS-1:0] row_n_reg, row_n_next;
    logic [COLS-1:0] col_reg, col_next;
    logic [COLS-1:0] cell_mask [MAX_LEN];

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cell
            assign cell_mask[gi] = (LW'(gi) < length && body[gi].r == COORD_W'(scan_reg))
                                   ? (COLS'(1) << body[gi].c) : '0;
        end
    endgenerate

    always_comb begin
        scan_next  = (scan_reg == SW'(ROWS - 1)) ? '0 : scan_reg + SW'(1);
        row_n_next = ~(ROWS'(1) << scan_reg);
        col_next   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            col_next = col_next | cell_mask[i];
        end
        if (food_valid && food.r == COORD_W'(scan_reg)) begin
            col_next = col_next | (COLS'(1) << food.c);
        end
    end

    always_ff @(posedge clkSlw or posedge reset) begin
        if (reset) begin
            scan_reg  <= '0;
            row_n_reg <= '1;
            col_reg   <= '0;
        end else begin
            scan_reg  <= scan_next;
            row_n_reg <= row_n_next;
            col_reg   <= col_next;
        end
    end

    assign row_n = row_n_reg;
    assign col   = col_reg;

endmodule

// File: rtl/snake_engine.sv
// Snake game on a ROWS x COLS LED matrix with a coordinate body buffer.
// Define SNAKE_FOOD_EN to add LFSR-placed food and growth up to MAX_LEN.
module snake_engine
    import snake_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int TICK_DIV = 8
) (
    input  logic                         clkSlw,
    input  logic                         reset,
    input  logic                         derecha,
    input  logic                         izquierda,
    input  logic                         start,
    output logic [ROWS-1:0]              row_n,
    output logic [COLS-1:0]              col,
    output logic                         running,
    output logic                         game_over,
    output logic [$clog2(MAX_LEN+1)-1:0] length
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TICK_DIV);

    state_e             state_reg, state_next;
    dir_e               dir_reg, dir_next, move_dir;
    turn_e              pend_reg, pend_next;
    logic [TW-1:0]      tick_reg, tick_next;
    logic               der_prev_reg, izq_prev_reg, der_edge, izq_edge;
    coord_t             pos_reg  [MAX_LEN];
    coord_t             pos_next [MAX_LEN];
    logic [LW-1:0]      len_reg, len_next, hit_lim;
    logic               running_reg, game_over_reg;
    coord_t             new_head, food_cell;
    logic [MAX_LEN-1:0] hit_vec;
    logic               move, grow, food_on;
`ifdef SNAKE_FOOD_EN
    logic [15:0]        lfsr_reg;
    coord_t             food_reg, food_next, cand;
    logic               food_valid_reg, food_valid_next, seek_reg, seek_next;
    logic               eat, ate, restart;
    logic [MAX_LEN-1:0] cand_vec;
`endif

    function automatic coord_t init_cell(int i);
        coord_t p;
        p.r = '0;
        p.c = (i < INIT_LEN) ? COORD_W'(INIT_LEN - 1 - i) : '0;
        return p;
    endfunction

    function automatic coord_t step(coord_t p, dir_e d);
        coord_t q = p;
        case (d)
            DIR_E:   q.c = (p.c == COORD_W'(COLS - 1)) ? '0 : p.c + COORD_W'(1);
            DIR_W:   q.c = (p.c == '0) ? COORD_W'(COLS - 1) : p.c - COORD_W'(1);
            DIR_S:   q.r = (p.r == COORD_W'(ROWS - 1)) ? '0 : p.r + COORD_W'(1);
            default: q.r = (p.r == '0) ? COORD_W'(ROWS - 1) : p.r - COORD_W'(1);
        endcase
        return q;
    endfunction

    always_comb begin
        der_edge = derecha & ~der_prev_reg;
        izq_edge = izquierda & ~izq_prev_reg;
        move     = (state_reg == ST_RUN) && (tick_reg == TW'(TICK_DIV - 1));
        move_dir = apply_turn(dir_reg, pend_reg);
        new_head = step(pos_reg[0], move_dir);
`ifdef SNAKE_FOOD_EN
        eat  = food_valid_reg && (new_head == food_reg);
        grow = eat && (len_reg < LW'(MAX_LEN));
`else
        grow = 1'b0;
`endif
        // The tail cell vacates on a normal move, so it only blocks the head when growing.
        hit_lim = grow ? len_reg : len_reg - LW'(1);
    end

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_hit
            assign hit_vec[gi] = (LW'(gi) < hit_lim) && (pos_reg[gi] == new_head);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        pend_next  = pend_reg;
        tick_next  = tick_reg;
        pos_next   = pos_reg;
        len_next   = len_reg;
`ifdef SNAKE_FOOD_EN
        restart = 1'b0;
        ate     = 1'b0;
`endif
        case (state_reg)
            ST_RUN: begin
                if (move) begin
                    tick_next = '0;
                    dir_next  = move_dir;
                    pend_next = TURN_NONE;
                    if (|hit_vec) begin
                        state_next = ST_OVER;
                    end else begin
                        for (int i = MAX_LEN - 1; i > 0; i--) begin
                            pos_next[i] = pos_reg[i-1];
                        end
                        pos_next[0] = new_head;
`ifdef SNAKE_FOOD_EN
                        if (grow) len_next = len_reg + LW'(1);
                        ate = eat;
`endif
                    end
                end else begin
                    tick_next = tick_reg + TW'(1);
                end
                if (der_edge && !izq_edge)      pend_next = TURN_CW;
                else if (izq_edge && !der_edge) pend_next = TURN_CCW;
            end
            default: begin
                if (start) begin
                    state_next = ST_RUN;
                    tick_next  = '0;
                    dir_next   = DIR_E;
                    pend_next  = TURN_NONE;
                    len_next   = LW'(INIT_LEN);
                    for (int i = 0; i < MAX_LEN; i++) begin
                        pos_next[i] = init_cell(i);
                    end
`ifdef SNAKE_FOOD_EN
                    restart = 1'b1;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clkSlw or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            dir_reg       <= DIR_E;
            pend_reg      <= TURN_NONE;
            tick_reg      <= '0;
            der_prev_reg  <= 1'b0;
            izq_prev_reg  <= 1'b0;
            len_reg       <= LW'(INIT_LEN);
            running_reg   <= 1'b0;
            game_over_reg <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                pos_reg[i] <= init_cell(i);
            end
        end else begin
            state_reg     <= state_next;
            dir_reg       <= dir_next;
            pend_reg      <= pend_next;
            tick_reg      <= tick_next;
            der_prev_reg  <= derecha;
            izq_prev_reg  <= izquierda;
            len_reg       <= len_next;
            running_reg   <= (state_next == ST_RUN);
            game_over_reg <= (state_next == ST_OVER);
            pos_reg       <= pos_next;
        end
    end

`ifdef SNAKE_FOOD_EN
    always_comb begin
        cand.r = COORD_W'(32'(lfsr_reg[7:0]) % 32'(ROWS));
        cand.c = COORD_W'(32'(lfsr_reg[15:8]) % 32'(COLS));
    end

    // Candidates are checked against the body as it will be after this cycle.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cand
            assign cand_vec[gi] = (LW'(gi) < len_next) && (pos_next[gi] == cand);
        end
    endgenerate

    always_comb begin
        food_next       = food_reg;
        food_valid_next = food_valid_reg;
        seek_next       = seek_reg;
        if (restart || ate) begin
            food_valid_next = 1'b0;
            seek_next       = 1'b1;
        end else if (seek_reg && !(|cand_vec)) begin
            food_next       = cand;
            food_valid_next = 1'b1;
            seek_next       = 1'b0;
        end
    end

    always_ff @(posedge clkSlw or posedge reset) begin
        if (reset) begin
            lfsr_reg       <= LFSR_SEED;
            food_reg       <= '0;
            food_valid_reg <= 1'b0;
            seek_reg       <= 1'b0;
        end else begin
            lfsr_reg       <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
            food_reg       <= food_next;
            food_valid_reg <= food_valid_next;
            seek_reg       <= seek_next;
        end
    end

    assign food_cell = food_reg;
    assign food_on   = food_valid_reg;
`else
    assign food_cell = '0;
    assign food_on   = 1'b0;
`endif

    snake_scan #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .MAX_LEN (MAX_LEN)
    ) u_scan (
        .clkSlw     (clkSlw),
        .reset      (reset),
        .body       (pos_reg),
        .length     (len_reg),
        .food       (food_cell),
        .food_valid (food_on),
        .row_n      (row_n),
        .col        (col)
    );

    assign running   = running_reg;
    assign game_over = game_over_reg;
    assign length    = len_reg;

endmodule
